// File: rtl/aes_mode_controller.sv
// aes_mode_controller: streams FIFO blocks through an external AES core in ECB or CBC mode.
// CBC chaining and SET_IV support exist only when AES_CBC_MODE_EN is defined.
`timescale 1ns/1ps
`default_nettype none

`ifndef WORD_S
`define WORD_S 32
`endif
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef KEY_S
`define KEY_S 128
`endif
`ifndef SET_KEY
`define SET_KEY 32'h0000_0001
`endif
`ifndef SET_IV
`define SET_IV 32'h0000_0002
`endif
`ifndef ENCRYPT
`define ENCRYPT 32'h0000_0003
`endif
`ifndef DECRYPT
`define DECRYPT 32'h0000_0004
`endif

module aes_mode_controller #(
  parameter int IN_FIFO_ADDR_WIDTH  = 9,
  parameter int OUT_FIFO_ADDR_WIDTH = 9,
  parameter int FIFO_DATA_WIDTH     = 128
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [`WORD_S-1:0]             aes_cmd,
  input  logic                           cbc_mode,
  input  logic [FIFO_DATA_WIDTH-1:0]     in_fifo_data,
  input  logic [IN_FIFO_ADDR_WIDTH-1:0]  in_fifo_blk_cnt,
  output logic                           in_fifo_r_e,
  output logic [IN_FIFO_ADDR_WIDTH-1:0]  in_fifo_addr,
  output logic                           out_fifo_w_e,
  output logic [OUT_FIFO_ADDR_WIDTH-1:0] out_fifo_addr,
  output logic [FIFO_DATA_WIDTH-1:0]     out_fifo_data,
  output logic                           core_start,
  output logic [`WORD_S-1:0]             core_cmd,
  output logic [`KEY_S-1:0]              core_key,
  output logic [`BLK_S-1:0]              core_in_blk,
  input  logic [`BLK_S-1:0]              core_out_blk,
  input  logic                           core_done,
  output logic                           busy,
  output logic                           en_o,
  output logic                           err_o
);

  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DONE} state_t;

  state_t                         state;
  logic [`WORD_S-1:0]             cmd_q;
  logic                           err_q;
  logic [IN_FIFO_ADDR_WIDTH-1:0]  blk_cnt_q;
  logic [IN_FIFO_ADDR_WIDTH-1:0]  read_ptr;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] write_ptr;
  logic [IN_FIFO_ADDR_WIDTH-1:0]  rp_next;
  logic [`BLK_S-1:0]              data_sw;
  logic [`BLK_S-1:0]              blk_in_next;
  logic [`BLK_S-1:0]              result;
  logic                           cmd_known;
  logic                           is_set_iv;

  // Reverse the byte order inside every 32-bit word (byte i <-> byte i^3).
  function automatic logic [`BLK_S-1:0] bswap(input logic [`BLK_S-1:0] d);
    logic [`BLK_S-1:0] r;
    for (int i = 0; i < `BLK_S/8; i++) r[i*8 +: 8] = d[(i ^ 3)*8 +: 8];
    return r;
  endfunction

  assign data_sw = bswap(in_fifo_data);
  assign rp_next = read_ptr + IN_FIFO_ADDR_WIDTH'(1);

`ifdef AES_CBC_MODE_EN
  logic              cbc_q;
  logic [`BLK_S-1:0] iv_q;
  logic [`BLK_S-1:0] chain_q;
  logic [`BLK_S-1:0] in_blk_q;

  assign is_set_iv = (cmd_q == `SET_IV);
  assign cmd_known = (aes_cmd == `SET_KEY) || (aes_cmd == `ENCRYPT) ||
                     (aes_cmd == `DECRYPT) || (aes_cmd == `SET_IV);

  always_comb begin
    blk_in_next = data_sw;
    result      = core_out_blk;
    if (cmd_q == `SET_KEY)                   blk_in_next = '0;
    else if (cbc_q && cmd_q == `ENCRYPT)     blk_in_next = data_sw ^ chain_q;
    if (cbc_q && cmd_q == `DECRYPT)          result      = core_out_blk ^ chain_q;
  end

  // The chain restarts from the IV on every command; only SET_IV rewrites the IV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cbc_q    <= 1'b0;
      iv_q     <= '0;
      chain_q  <= '0;
      in_blk_q <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          cbc_q   <= cbc_mode;
          chain_q <= iv_q;
        end
        START: begin
          in_blk_q <= data_sw;
          if (cmd_q == `SET_IV) iv_q <= data_sw;
        end
        WAIT: if (core_done && cbc_q) begin
          if (cmd_q == `ENCRYPT)      chain_q <= core_out_blk;
          else if (cmd_q == `DECRYPT) chain_q <= in_blk_q;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_cbc_mode;
  assign unused_cbc_mode = cbc_mode;
  assign is_set_iv = 1'b0;
  assign cmd_known = (aes_cmd == `SET_KEY) || (aes_cmd == `ENCRYPT) ||
                     (aes_cmd == `DECRYPT);

  always_comb begin
    blk_in_next = (cmd_q == `SET_KEY) ? '0 : data_sw;
    result      = core_out_blk;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cmd_q         <= '0;
      err_q         <= 1'b0;
      blk_cnt_q     <= '0;
      read_ptr      <= '0;
      write_ptr     <= '0;
      in_fifo_r_e   <= 1'b0;
      in_fifo_addr  <= '0;
      out_fifo_w_e  <= 1'b0;
      out_fifo_addr <= '0;
      out_fifo_data <= '0;
      core_start    <= 1'b0;
      core_cmd      <= '0;
      core_key      <= '0;
      core_in_blk   <= '0;
      busy          <= 1'b0;
      en_o          <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      in_fifo_r_e  <= 1'b0;
      out_fifo_w_e <= 1'b0;
      core_start   <= 1'b0;
      en_o         <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: if (en) begin
          cmd_q     <= aes_cmd;
          err_q     <= !cmd_known;
          blk_cnt_q <= in_fifo_blk_cnt;
          read_ptr  <= '0;
          write_ptr <= '0;
          busy      <= 1'b1;
          if (!cmd_known || in_fifo_blk_cnt == '0) begin
            state <= DONE;
          end else begin
            state        <= FETCH;
            in_fifo_r_e  <= 1'b1;
            in_fifo_addr <= '0;
          end
        end
        FETCH: state <= START;
        START: begin
          if (is_set_iv) begin
            state <= DONE;
          end else begin
            core_start  <= 1'b1;
            core_cmd    <= cmd_q;
            core_key    <= (cmd_q == `SET_KEY) ? data_sw : '0;
            core_in_blk <= blk_in_next;
            state       <= WAIT;
          end
        end
        WAIT: if (core_done) begin
          if (cmd_q == `SET_KEY) begin
            state <= DONE;
          end else begin
            out_fifo_w_e  <= 1'b1;
            out_fifo_addr <= write_ptr;
            out_fifo_data <= bswap(result);
            read_ptr      <= rp_next;
            write_ptr     <= write_ptr + OUT_FIFO_ADDR_WIDTH'(1);
            if (rp_next == blk_cnt_q) begin
              state <= DONE;
            end else begin
              state        <= FETCH;
              in_fifo_r_e  <= 1'b1;
              in_fifo_addr <= rp_next;
            end
          end
        end
        DONE: begin
          en_o  <= 1'b1;
          err_o <= err_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_mode_controller.sv
// tb_aes_mode_controller: randomized directed bench with a toy reversible cipher standing in for the AES core.
// Expected FIFO writes come from a block-level mode model (ECB/CBC rules on byte-swapped words).
`timescale 1ns/1ps
`default_nettype none

`ifndef WORD_S
`define WORD_S 32
`endif
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef KEY_S
`define KEY_S 128
`endif
`ifndef SET_KEY
`define SET_KEY 32'h0000_0001
`endif
`ifndef SET_IV
`define SET_IV 32'h0000_0002
`endif
`ifndef ENCRYPT
`define ENCRYPT 32'h0000_0003
`endif
`ifndef DECRYPT
`define DECRYPT 32'h0000_0004
`endif

module tb_aes_mode_controller;
  localparam int IN_W  = 5;
  localparam int OUT_W = 4;
`ifdef AES_CBC_MODE_EN
  localparam bit CBC_EN = 1'b1;
`else
  localparam bit CBC_EN = 1'b0;
`endif
  localparam logic [31:0] C_SET_KEY = `SET_KEY;
  localparam logic [31:0] C_SET_IV  = `SET_IV;
  localparam logic [31:0] C_ENC     = `ENCRYPT;
  localparam logic [31:0] C_DEC     = `DECRYPT;
  localparam logic [31:0] C_BAD     = 32'h0000_dead;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic [31:0]       aes_cmd = '0;
  logic              cbc_mode = 1'b0;
  logic [127:0]      in_fifo_data;
  logic [IN_W-1:0]   in_fifo_blk_cnt = '0;
  logic              in_fifo_r_e;
  logic [IN_W-1:0]   in_fifo_addr;
  logic              out_fifo_w_e;
  logic [OUT_W-1:0]  out_fifo_addr;
  logic [127:0]      out_fifo_data;
  logic              core_start;
  logic [31:0]       core_cmd;
  logic [127:0]      core_key;
  logic [127:0]      core_in_blk;
  logic [127:0]      core_out_blk = '0;
  logic              core_done = 1'b0;
  logic              busy, en_o, err_o;

  aes_mode_controller #(
    .IN_FIFO_ADDR_WIDTH (IN_W),
    .OUT_FIFO_ADDR_WIDTH(OUT_W),
    .FIFO_DATA_WIDTH    (128)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .aes_cmd(aes_cmd), .cbc_mode(cbc_mode),
    .in_fifo_data(in_fifo_data), .in_fifo_blk_cnt(in_fifo_blk_cnt),
    .in_fifo_r_e(in_fifo_r_e), .in_fifo_addr(in_fifo_addr),
    .out_fifo_w_e(out_fifo_w_e), .out_fifo_addr(out_fifo_addr), .out_fifo_data(out_fifo_data),
    .core_start(core_start), .core_cmd(core_cmd), .core_key(core_key), .core_in_blk(core_in_blk),
    .core_out_blk(core_out_blk), .core_done(core_done),
    .busy(busy), .en_o(en_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_en_o, n_err_o, n_wr, n_start;
  int exp_writes, exp_starts;
  int fixed_lat = 0;

  typedef struct { logic [OUT_W-1:0] addr; logic [127:0] data; } wr_t;
  wr_t          exp_q[$];
  logic [127:0] in_mem [0:31];
  logic [127:0] out_mem [0:15];
  logic [127:0] m_key = '0;
  logic [127:0] m_iv = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] sw(input logic [127:0] d);
    logic [127:0] r;
    for (int w = 0; w < 4; w++)
      r[w*32 +: 32] = {d[w*32 +: 8], d[w*32+8 +: 8], d[w*32+16 +: 8], d[w*32+24 +: 8]};
    return r;
  endfunction

  // Stand-in block cipher: E(x) = rotl13(x ^ k), D(y) = rotr13(y) ^ k.
  function automatic logic [127:0] toy_enc(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] t;
    t = x ^ k;
    return {t[114:0], t[127:115]};
  endfunction
  function automatic logic [127:0] toy_dec(input logic [127:0] y, input logic [127:0] k);
    return {y[12:0], y[127:13]} ^ k;
  endfunction

  // Synchronous-read input FIFO: data appears the cycle after the strobe.
  always @(posedge clk)
    in_fifo_data <= in_fifo_r_e ? in_mem[in_fifo_addr] : {$urandom, $urandom, $urandom, $urandom};

  // Core model with its own state; deliberately not reset by reset_n.
  logic [127:0] cm_key = '0;
  logic [127:0] cm_in = '0;
  logic [31:0]  cm_cmd = '0;
  int           cm_cnt = 0;
  always @(posedge clk) begin
    core_done    <= 1'b0;
    core_out_blk <= {$urandom, $urandom, $urandom, $urandom};
    if (core_start) begin
      cm_cmd <= core_cmd;
      cm_in  <= core_in_blk;
      if (core_cmd == C_SET_KEY) cm_key <= core_key;
      cm_cnt <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (cm_cnt == 1) begin
      cm_cnt       <= 0;
      core_done    <= 1'b1;
      core_out_blk <= (cm_cmd == C_DEC) ? toy_dec(cm_in, cm_key) : toy_enc(cm_in, cm_key);
    end else if (cm_cnt > 1) begin
      cm_cnt <= cm_cnt - 1;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (en_o)       n_en_o++;
    if (err_o)      n_err_o++;
    if (core_start) n_start++;
    if (core_done && busy) begin
      chk("core_in_stable", core_in_blk, cm_in);
      chk("core_cmd_stable", {96'd0, core_cmd}, {96'd0, cm_cmd});
    end
    if (out_fifo_w_e) begin
      n_wr++;
      out_mem[out_fifo_addr] = out_fifo_data;
      chk("write_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {124'd0, out_fifo_addr}, {124'd0, e.addr});
        chk("wr_data", out_fifo_data, e.data);
      end
    end
  end

  // Block-level mode model: fills exp_q and the expected pulse counts.
  task automatic model_cmd(input logic [31:0] cmd, input bit cbc, input int n, output bit err);
    bit           known, cbc_e;
    logic [127:0] chain, x, y;
    wr_t          w;
    known = (cmd == C_SET_KEY) || (cmd == C_ENC) || (cmd == C_DEC) || (cmd == C_SET_IV && CBC_EN);
    cbc_e = cbc && CBC_EN;
    err = !known;
    exp_writes = 0;
    exp_starts = 0;
    chain = m_iv;
    if (!known || n == 0) return;
    if (cmd == C_SET_KEY) begin
      m_key = sw(in_mem[0]);
      exp_starts = 1;
    end else if (cmd == C_SET_IV) begin
      m_iv = sw(in_mem[0]);
    end else begin
      for (int i = 0; i < n; i++) begin
        x = sw(in_mem[i]);
        if (cmd == C_ENC) begin
          y = toy_enc(cbc_e ? (x ^ chain) : x, m_key);
          if (cbc_e) chain = y;
        end else begin
          y = toy_dec(x, m_key) ^ (cbc_e ? chain : 128'd0);
          if (cbc_e) chain = x;
        end
        w.addr = OUT_W'(i);
        w.data = sw(y);
        exp_q.push_back(w);
        exp_writes++;
        exp_starts++;
      end
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) in_mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_cmd(input logic [31:0] cmd, input bit cbc, input int n);
    en = 1'b1; aes_cmd = cmd; cbc_mode = cbc; in_fifo_blk_cnt = IN_W'(n);
    @(negedge clk);
    en = 1'b0; aes_cmd = $urandom; cbc_mode = 1'($urandom); in_fifo_blk_cnt = IN_W'($urandom);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] cmd, input bit cbc, input int n,
                         input bit poke, output int lat);
    bit exp_err;
    int cyc;
    n_en_o = 0; n_err_o = 0; n_wr = 0; n_start = 0;
    model_cmd(cmd, cbc, n, exp_err);
    start_cmd(cmd, cbc, n);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
    cyc = 1;
    while (!en_o && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      en = poke && (cyc % 7 == 3);
    end
    en = 1'b0;
    lat = cyc;
    chk({tag, "_en_o"}, {127'd0, en_o}, 128'd1);
    chk({tag, "_err_o"}, {127'd0, err_o}, {127'd0, exp_err});
    chk({tag, "_idle"}, {127'd0, busy}, 128'd0);
    @(negedge clk);
    chk({tag, "_en_pulses"}, 128'(n_en_o), 128'd1);
    chk({tag, "_err_pulses"}, 128'(n_err_o), 128'(exp_err));
    chk({tag, "_writes"}, 128'(n_wr), 128'(exp_writes));
    chk({tag, "_starts"}, 128'(n_start), 128'(exp_starts));
    chk({tag, "_pending"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat1, lat2, starts, cyc, sel;
    logic [31:0] rc;
    bit dummy;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {127'd0, |{busy, en_o, err_o, in_fifo_r_e, in_fifo_addr, out_fifo_w_e,
        out_fifo_addr, out_fifo_data, core_start, core_cmd, core_key, core_in_blk}}, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    fill(3);
    run_cmd("set_key", C_SET_KEY, 1'b0, 3, 1'b0, lat);

    fixed_lat = 1;
    fill(2);
    run_cmd("ecb1", C_ENC, 1'b0, 1, 1'b0, lat1);
    run_cmd("ecb2", C_ENC, 1'b0, 2, 1'b0, lat2);
    chk("block_latency", 128'(lat2 - lat1), 128'(fixed_lat + 1 + 3));
    fixed_lat = 0;

    run_cmd("empty", C_ENC, 1'b0, 0, 1'b0, lat);
    chk("empty_latency", 128'(lat), 128'd2);
    fill(2);
    run_cmd("unknown", C_BAD, 1'b0, 2, 1'b0, lat);

    fill(1);
    run_cmd("set_iv", C_SET_IV, 1'b0, 1, 1'b0, lat);
    fill(4);
    run_cmd("cbc_enc", C_ENC, 1'b1, 4, 1'b0, lat);
    for (int i = 0; i < 4; i++) in_mem[i] = out_mem[i];
    run_cmd("cbc_dec", C_DEC, 1'b1, 4, 1'b0, lat);
    fill(4);
    run_cmd("cbc_enc_again", C_ENC, 1'b1, 4, 1'b0, lat);

    fill(31);
    run_cmd("max_blocks", C_DEC, 1'b1, 31, 1'b0, lat);
    fill(6);
    run_cmd("en_while_busy", C_ENC, 1'b0, 6, 1'b1, lat);

    // Reset while block 2 of 4 waits on the core.
    fill(4);
    n_en_o = 0; n_wr = 0;
    model_cmd(C_ENC, 1'b0, 4, dummy);
    start_cmd(C_ENC, 1'b0, 4);
    starts = 0; cyc = 0;
    while (starts < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (core_start) starts++;
    end
    chk("rst_reached_block2", 128'(starts), 128'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {127'd0, |{busy, en_o, err_o, in_fifo_r_e, in_fifo_addr, out_fifo_w_e,
        out_fifo_addr, out_fifo_data, core_start, core_cmd, core_key, core_in_blk}}, 128'd0);
    exp_q.delete();
    m_iv = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_en_o", 128'(n_en_o), 128'd0);
    chk("rst_writes_before", 128'(n_wr), 128'd1);
    fill(1);
    run_cmd("after_reset", C_ENC, 1'b0, 1, 1'b0, lat);

    for (int k = 0; k < 16; k++) begin
      sel = int'($urandom_range(0, 9));
      rc = (sel == 0) ? C_SET_KEY : (sel == 1) ? C_SET_IV : (sel == 2) ? C_BAD :
           (sel < 7) ? C_ENC : C_DEC;
      fill(8);
      run_cmd("random", rc, 1'($urandom), int'($urandom_range(0, 8)), 1'b0, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
